snake_step_ctrl: RTL and testbench

//   Sequencer for the LED snake. Divides clk into step ticks, advances a 5-bit head position with

---
 rtl/snake_if.sv | 27 ++
 rtl/snake_step_ctrl.sv | 123 ++++++++++++
 tb/tb_snake_step_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/snake_if.sv
// snake_if: control/status bundle between the user controls and the LED snake sequencer
// Ports (via modports):
//   master drives en, pause, dir, speed and observes step, lap, head, led, busy
//   slave  (snake_step_ctrl) is the mirror image
interface snake_if #(
    parameter int NUM_LEDS = 8
);
    logic                en;
    logic                pause;
    logic                dir;
    logic [1:0]          speed;
    logic                step;
    logic                lap;
    logic [4:0]          head;
    logic [NUM_LEDS-1:0] led;
    logic                busy;

    modport master (
        output en, pause, dir, speed,
        input  step, lap, head, led, busy
    );

    modport slave (
        input  en, pause, dir, speed,
        output step, lap, head, led, busy
    );
endinterface

// File: rtl/snake_step_ctrl.sv
// snake_step_ctrl: LED snake sequencer, divides clk into step ticks and drives the head index and LED mask
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  snake_if.slave: en/pause/dir/speed in; step/lap/head/led/busy out
// Build option: define SNAKE_BOUNCE_EN to bounce at the strip ends instead of wrapping.
module snake_step_ctrl #(
    parameter int CLK_DIV   = 5_000_000,
    parameter int NUM_LEDS  = 8,
    parameter int SNAKE_LEN = 3
) (
    input logic    clk,
    input logic    rst,
    snake_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    localparam logic [4:0]          LAST = 5'(NUM_LEDS - 1);
    localparam logic [NUM_LEDS-1:0] ONE  = NUM_LEDS'(1);

    state_t              state;
    logic [31:0]         timer;
    logic [31:0]         per;
    logic                fire;
    logic [4:0]          head_q;
    logic [4:0]          nxt_head;
    logic                dir_q;
    logic                nxt_dir;
    logic                nxt_lap;
    logic                step_q;
    logic                lap_q;
    logic [NUM_LEDS-1:0] led_c;
    int                  t;

    assign per  = 32'(CLK_DIV) >> bus.speed;
    // >= rather than == so a speed increase past the current count fires on the next cycle
    assign fire = timer >= per - 32'd1;

`ifdef SNAKE_BOUNCE_EN
    // direction only flips at the ends; a flip is exactly a lap
    assign nxt_dir  = (!dir_q && head_q == LAST) ? 1'b1 : (dir_q && head_q == 5'd0) ? 1'b0 : dir_q;
    assign nxt_lap  = nxt_dir != dir_q;
    assign nxt_head = nxt_dir ? head_q - 5'd1 : head_q + 5'd1;
`else
    assign nxt_dir  = bus.dir;
    assign nxt_lap  = nxt_dir ? head_q == 5'd0 : head_q == LAST;
    assign nxt_head = nxt_lap ? (nxt_dir ? LAST : 5'd0) : nxt_dir ? head_q - 5'd1 : head_q + 5'd1;
`endif

    // trail sits behind the head: below it when moving up, above it when moving down
    always_comb begin
        led_c = '0;
        t     = 0;
        for (int k = 0; k < SNAKE_LEN; k++) begin
            t = dir_q ? int'(head_q) + k : int'(head_q) - k;
`ifdef SNAKE_BOUNCE_EN
            if (state != IDLE && t >= 0 && t < NUM_LEDS) led_c = led_c | (ONE << t);
`else
            t = t < 0 ? t + NUM_LEDS : t >= NUM_LEDS ? t - NUM_LEDS : t;
            if (state != IDLE) led_c = led_c | (ONE << t);
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            timer  <= '0;
            head_q <= '0;
            dir_q  <= 1'b0;
            step_q <= 1'b0;
            lap_q  <= 1'b0;
        end else begin
            step_q <= 1'b0;
            lap_q  <= 1'b0;
            case (state)
                IDLE: begin
                    timer  <= '0;
                    head_q <= '0;
                    if (bus.en) begin
                        state <= RUN;
                        dir_q <= bus.dir;
                    end
                end
                RUN: begin
                    if (!bus.en) begin
                        state  <= IDLE;
                        timer  <= '0;
                        head_q <= '0;
                    end else if (bus.pause) begin
                        state <= HOLD;
                    end else if (fire) begin
                        timer  <= '0;
                        step_q <= 1'b1;
                        lap_q  <= nxt_lap;
                        head_q <= nxt_head;
                        dir_q  <= nxt_dir;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                HOLD: begin
                    if (!bus.en) begin
                        state  <= IDLE;
                        timer  <= '0;
                        head_q <= '0;
                    end else if (!bus.pause) begin
                        // the edge that froze the count is paid back on release
                        state <= RUN;
                        timer <= timer + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.step = step_q;
    assign bus.lap  = lap_q;
    assign bus.head = head_q;
    assign bus.led  = led_c;
    assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_snake_step_ctrl.sv
// tb_snake_step_ctrl: directed self-checking bench for snake_step_ctrl (CLK_DIV=8, NUM_LEDS=8, SNAKE_LEN=3)
module tb_snake_step_ctrl;
    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   n;
    int   stuck;

    snake_if #(.NUM_LEDS(8)) bus ();

    snake_step_ctrl #(.CLK_DIV(8), .NUM_LEDS(8), .SNAKE_LEN(3)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_step(input int max, output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!bus.step && cnt < max);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.en = 1'b0;
        bus.pause = 1'b0;
        bus.dir = 1'b0;
        bus.speed = 2'd0;
        repeat (2) tick();
        rst = 1'b0;
        chk("rst_head", 32'(bus.head), 0);
        chk("rst_led", 32'(bus.led), 0);
        chk("rst_step", 32'(bus.step), 0);
        chk("rst_busy", 32'(bus.busy), 0);

        // async reset landing on a step pulse, checked before any further clock edge
        bus.en = 1'b1;
        tick();
        wait_step(20, n);
        chk("pre_rst_n", 32'(n), 8);
        chk("pre_rst_step", 32'(bus.step), 1);
        chk("pre_rst_head", 32'(bus.head), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_head", 32'(bus.head), 0);
        chk("arst_led", 32'(bus.led), 0);
        chk("arst_step", 32'(bus.step), 0);
        chk("arst_busy", 32'(bus.busy), 0);
        bus.en = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        bus.en = 1'b1;
        bus.dir = 1'b0;
        bus.speed = 2'd0;
        tick();
        chk("run_busy", 32'(bus.busy), 1);
        chk("run_led0", 32'(bus.led), 32'hC1);
        chk("run_step0", 32'(bus.step), 0);
`ifdef SNAKE_BOUNCE_EN
        for (int i = 1; i <= 9; i++) begin
            wait_step(20, n);
            chk($sformatf("bn_n%0d", i), 32'(n), 8);
            chk($sformatf("bn_head%0d", i), 32'(bus.head), 32'(i <= 7 ? i : 14 - i));
            chk($sformatf("bn_lap%0d", i), 32'(bus.lap), 32'(i == 8));
            if (i == 8) chk("bn_led8", 32'(bus.led), 32'hC0);
            if (i == 9) chk("bn_led9", 32'(bus.led), 32'hE0);
        end
        bus.en = 1'b0;
        tick();
        chk("bn_idle_led", 32'(bus.led), 0);
`else
        for (int i = 1; i <= 8; i++) begin
            wait_step(20, n);
            chk($sformatf("up_n%0d", i), 32'(n), 8);
            chk($sformatf("up_head%0d", i), 32'(bus.head), 32'(i % 8));
            chk($sformatf("up_lap%0d", i), 32'(bus.lap), 32'(i == 8));
            if (i == 1) chk("up_led1", 32'(bus.led), 32'h83);
            if (i == 8) chk("up_led8", 32'(bus.led), 32'hC1);
        end
        tick();
        chk("step_pulse_len", 32'(bus.step), 0);
        chk("lap_pulse_len", 32'(bus.lap), 0);

        bus.dir = 1'b1;
        wait_step(20, n);
        chk("dn_n", 32'(n), 7);
        chk("dn_head7", 32'(bus.head), 7);
        chk("dn_lap", 32'(bus.lap), 1);
        chk("dn_led7", 32'(bus.led), 32'h83);
        wait_step(20, n);
        chk("dn_head6", 32'(bus.head), 6);
        chk("dn_lap6", 32'(bus.lap), 0);
        chk("dn_led6", 32'(bus.led), 32'hC1);

        repeat (5) tick();
        bus.pause = 1'b1;
        tick();
        chk("hold_busy", 32'(bus.busy), 1);
        chk("hold_step", 32'(bus.step), 0);
        stuck = 0;
        repeat (19) begin
            tick();
            if (bus.step !== 1'b0 || bus.head !== 5'd6) stuck++;
        end
        chk("hold_frozen", 32'(stuck), 0);
        bus.pause = 1'b0;
        tick();
        chk("release_step", 32'(bus.step), 0);
        wait_step(20, n);
        chk("release_n", 32'(n), 2);
        chk("release_head", 32'(bus.head), 5);

        repeat (5) tick();
        bus.speed = 2'd2;
        wait_step(20, n);
        chk("spd_n1", 32'(n), 1);
        chk("spd_head4", 32'(bus.head), 4);
        wait_step(20, n);
        chk("spd_n2", 32'(n), 2);
        chk("spd_head3", 32'(bus.head), 3);
        wait_step(20, n);
        chk("spd_n3", 32'(n), 2);
        chk("spd_head2", 32'(bus.head), 2);

        bus.en = 1'b0;
        tick();
        chk("off_step", 32'(bus.step), 0);
        chk("off_busy", 32'(bus.busy), 0);
        chk("off_led", 32'(bus.led), 0);
        chk("off_head", 32'(bus.head), 0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
